board_reset_btn_conditioner: RTL and testbench

//   Board-level reset sequencer and button conditioner for the ULX3S top level, in the clk_25mhz domain.

---
 rtl/board_reset_btn_conditioner.sv | 140 ++++++++++++++
 tb/tb_board_reset_btn_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/board_reset_btn_conditioner.sv
// Board reset sequencer and button conditioner for the clk_25mhz domain.
// Stretches reset until PLL lock is stable, then debounces buttons into levels and edge pulses.
module board_reset_btn_conditioner #(
    parameter int                  NUM_BTNS        = 7,
    parameter logic [NUM_BTNS-1:0] BTN_ACTIVE_LOW  = 7'b0000001,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 250000,
    parameter int                  RST_HOLD_CYCLES = 16
) (
    input  logic                clk_25mhz,
    input  logic                reset,
    input  logic                pll_locked,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic                rst_out,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    localparam int RST_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [RST_W-1:0] HOLD_MAX = RST_W'(RST_HOLD_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } rst_state_t;

    rst_state_t          state_q, state_d;
    logic [RST_W-1:0]    hold_cnt_q, hold_cnt_d;

    logic [NUM_BTNS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTNS-1:0] sync_d [SYNC_STAGES];
    logic [NUM_BTNS-1:0] btn_s;

    logic [DB_W-1:0]     db_cnt_q [NUM_BTNS];
    logic [DB_W-1:0]     db_cnt_d [NUM_BTNS];

    logic [NUM_BTNS-1:0] level_q, level_d;
    logic [NUM_BTNS-1:0] press_q, press_d;
    logic [NUM_BTNS-1:0] release_q, release_d;
    logic                hold_next;

    // Reset sequencer: rst_out is the registered HOLD state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (!pll_locked) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + RST_W'(1);
                end
            end
            ST_RUN: begin
                if (!pll_locked) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign hold_next = (state_d == ST_HOLD);

    // Synchroniser chain; the last stage is polarity-normalised to 1 = pressed.
    always_comb begin
        sync_d[0] = btn_raw;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        btn_s = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;
    end

    // Per-button debounce: any disagreement shorter than the full window restarts the count.
    always_comb begin
        for (int i = 0; i < NUM_BTNS; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (btn_s[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
                level_d[i]  = ~level_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Pulses are masked by the next reset state so a pulse never coexists with rst_out=1.
    always_comb begin
        press_d   = level_d & ~level_q & {NUM_BTNS{~hold_next}};
        release_d = ~level_d & level_q & {NUM_BTNS{~hold_next}};
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= BTN_ACTIVE_LOW;
            end
            for (int i = 0; i < NUM_BTNS; i++) begin
                db_cnt_q[i] <= '0;
            end
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < NUM_BTNS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
        end
    end

    assign rst_out     = (state_q == ST_HOLD);
    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_board_reset_btn_conditioner.sv
// Bench for board_reset_btn_conditioner: directed scenarios plus random stimulus,
// checked every cycle against a window/run-length model of reset and debounce behaviour.
module tb_board_reset_btn_conditioner;

  localparam int N     = 7;
  localparam logic [N-1:0] ACT_LOW = 7'b0000001;
  localparam int SYNC  = 2;
  localparam int DB    = 8;
  localparam int HOLD  = 4;

  logic         clk_25mhz = 1'b0;
  logic         reset;
  logic         pll_locked;
  logic [N-1:0] btn_raw;
  logic         rst_out;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int tests = 0;
  int fails = 0;

  board_reset_btn_conditioner #(
    .NUM_BTNS(N), .BTN_ACTIVE_LOW(ACT_LOW), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DB), .RST_HOLD_CYCLES(HOLD)
  ) dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .pll_locked(pll_locked), .btn_raw(btn_raw),
    .rst_out(rst_out), .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  // clock / reset
  always #5 clk_25mhz = ~clk_25mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  // rst_out is low once at least HOLD consecutive locked, non-reset edges have been seen.
  // A level flips once the synchronised value has disagreed with it on each of the last DB edges.
  logic [N-1:0] m_level, m_press, m_release, m_old, s_used, flip;
  logic         m_rst;
  bit           m_valid = 0;
  bit           all_diff;
  int           lock_run;
  logic [N-1:0] pipe_q[$];
  logic [N-1:0] hist_q[$];

  always @(posedge clk_25mhz) begin
    if (reset) begin
      m_valid   = 1;
      lock_run  = 0;
      m_rst     = 1'b1;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      pipe_q.delete();
      for (int k = 0; k < SYNC; k++) pipe_q.push_back('0);
      hist_q.delete();
    end else if (m_valid) begin
      s_used = pipe_q.pop_front();
      pipe_q.push_back(btn_raw ^ ACT_LOW);
      lock_run = pll_locked ? ((lock_run < 1000) ? lock_run + 1 : lock_run) : 0;
      m_rst = (lock_run < HOLD);
      hist_q.push_back(s_used);
      if (hist_q.size() > DB) void'(hist_q.pop_front());
      m_old = m_level;
      flip  = '0;
      if (hist_q.size() == DB) begin
        for (int i = 0; i < N; i++) begin
          all_diff = 1;
          for (int j = 0; j < DB; j++) if (hist_q[j][i] == m_old[i]) all_diff = 0;
          flip[i] = all_diff;
        end
      end
      m_level   = m_old ^ flip;
      m_press   = m_level & ~m_old & {N{~m_rst}};
      m_release = ~m_level & m_old & {N{~m_rst}};
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk_25mhz) begin
    if (m_valid) begin
      chk("rst_out", 32'(rst_out), 32'(m_rst));
      chk("btn_level", 32'(btn_level), 32'(m_level));
      chk("btn_press", 32'(btn_press), 32'(m_press));
      chk("btn_release", 32'(btn_release), 32'(m_release));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b1;
    btn_raw    = ACT_LOW;

    // 1: reset release with lock held
    tick(3);
    chk("t1_reset_rst", 32'(rst_out), 32'd1);
    chk("t1_reset_level", 32'(btn_level), 32'd0);
    chk("t1_reset_press", 32'(btn_press), 32'd0);
    chk("t1_reset_release", 32'(btn_release), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk("t1_hold", 32'(rst_out), 32'(k < 4));
    end
    tick(3);
    chk("t1_run", 32'(rst_out), 32'd0);

    // 2: lock glitch during hold, then lock loss in run
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(2);
    pll_locked = 1'b0; tick(1); pll_locked = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk("t2_relock", 32'(rst_out), 32'(k < 4));
    end
    pll_locked = 1'b0; tick(1);
    chk("t2_drop", 32'(rst_out), 32'd1);
    pll_locked = 1'b1; tick(4);
    chk("t2_rerun", 32'(rst_out), 32'd0);

    // 3: clean press on button 3
    btn_raw[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 9) chk("t3_level_early", 32'(btn_level[3]), 32'd0);
    end
    chk("t3_level", 32'(btn_level[3]), 32'd1);
    chk("t3_press", 32'(btn_press[3]), 32'd1);
    tick(1);
    chk("t3_press_off", 32'(btn_press[3]), 32'd0);
    btn_raw[3] = 1'b0; tick(12);
    chk("t3_released", 32'(btn_level[3]), 32'd0);

    // 4: bounce shorter than the debounce window
    btn_raw[3] = 1'b1; tick(5); btn_raw[3] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("t4_bounce_level", 32'(btn_level[3]), 32'd0);
      chk("t4_bounce_press", 32'(btn_press[3]), 32'd0);
    end

    // 5: active-low button 0
    btn_raw[0] = 1'b0; tick(10);
    chk("t5_level", 32'(btn_level[0]), 32'd1);
    tick(3);
    btn_raw[0] = 1'b1; tick(9);
    chk("t5_rel_early", 32'(btn_release[0]), 32'd0);
    tick(1);
    chk("t5_release", 32'(btn_release[0]), 32'd1);
    chk("t5_level_off", 32'(btn_level[0]), 32'd0);
    tick(1);
    chk("t5_release_off", 32'(btn_release[0]), 32'd0);

    // 6a: press while rst_out is held
    pll_locked = 1'b0; tick(2);
    btn_raw[5] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("t6_no_press", 32'(btn_press[5]), 32'd0);
    end
    chk("t6_level", 32'(btn_level[5]), 32'd1);
    chk("t6_rst", 32'(rst_out), 32'd1);
    pll_locked = 1'b1; tick(6);
    btn_raw[5] = 1'b0; tick(12);

    // 6b: reset in the middle of a debounce
    btn_raw[2] = 1'b1; tick(5);
    reset = 1'b1; tick(1);
    chk("t6_mid_rst", 32'(rst_out), 32'd1);
    chk("t6_mid_level", 32'(btn_level), 32'd0);
    chk("t6_mid_press", 32'(btn_press), 32'd0);
    chk("t6_mid_release", 32'(btn_release), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 9) chk("t6_restart_early", 32'(btn_level[2]), 32'd0);
    end
    chk("t6_restart", 32'(btn_level[2]), 32'd1);
    btn_raw[2] = 1'b0; tick(12);

    // random phase
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      pll_locked = ($urandom_range(0, 99) < 97);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 14) == 0) btn_raw[i] = ~btn_raw[i];
      end
      tick(1);
    end
    reset = 1'b0; pll_locked = 1'b1;
    tick(20);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
